// File: rtl/mem_noc_arb.sv
// Two-requester round-robin arbiter onto one memory port, with an in-order
// owner FIFO that steers each downstream response back to its requester.
package mem_noc_pkg;
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } mem_resp_t;
endpackage

module mem_noc_arb
  import mem_noc_pkg::*;
#(
  parameter int OSD = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   m0_req_valid,
  output logic                   m0_req_ready,
  input  mem_req_t               m0_req,
  output logic                   m0_resp_valid,
  input  logic                   m0_resp_ready,
  output mem_resp_t              m0_resp,
  input  logic                   m1_req_valid,
  output logic                   m1_req_ready,
  input  mem_req_t               m1_req,
  output logic                   m1_resp_valid,
  input  logic                   m1_resp_ready,
  output mem_resp_t              m1_resp,
  output logic                   out_req_valid,
  input  logic                   out_req_ready,
  output mem_req_t               out_req,
  input  logic                   out_resp_valid,
  output logic                   out_resp_ready,
  input  mem_resp_t              out_resp,
  output logic [$clog2(OSD):0]   osd_cnt,
  output logic                   err_unexp_resp,
  output logic [1:0]             arb_state
);

  localparam int PW = $clog2(OSD);
  localparam int CW = PW + 1;

  // Every channel: a beat transfers on the rising edge where valid && ready;
  // valid never waits on ready, and a raised valid holds its payload until taken.
  typedef enum logic [1:0] {
    ARB_FREE  = 2'b00,
    ARB_LOCK0 = 2'b10,
    ARB_LOCK1 = 2'b11
  } arb_state_t;

  arb_state_t      state, state_n;
  logic            rr;
  logic            grant;
  logic            lock;
  logic            osd_full;
  logic            osd_empty;
  logic            push, pop;
  logic [OSD-1:0]  owner_q;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            head;

  assign lock      = (state != ARB_FREE);
  assign osd_full  = (osd_cnt == CW'(OSD));
  assign osd_empty = (osd_cnt == '0);
  assign head      = owner_q[rd_ptr];
  assign arb_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_FREE;
    end else begin
      state <= state_n;
    end
  end

  // A stalled offer pins the grant so the downstream payload cannot change under it.
  always_comb begin
    state_n = ARB_FREE;
    if (out_req_valid && !out_req_ready) begin
      state_n = grant ? ARB_LOCK1 : ARB_LOCK0;
    end
  end

  always_comb begin
    grant = 1'b0;
    case (state)
      ARB_LOCK0: grant = 1'b0;
      ARB_LOCK1: grant = 1'b1;
      default:   grant = (m0_req_valid && m1_req_valid) ? rr : m1_req_valid;
    endcase
    out_req_valid = !rst && (m0_req_valid || m1_req_valid || lock) && !osd_full;
    out_req       = grant ? m1_req : m0_req;
    m0_req_ready  = !rst && !grant && out_req_ready && !osd_full;
    m1_req_ready  = !rst &&  grant && out_req_ready && !osd_full;
  end

  // Responses follow the owner recorded at the FIFO head; an empty FIFO sinks them.
  always_comb begin
    m0_resp        = out_resp;
    m1_resp        = out_resp;
    m0_resp_valid  = !rst && out_resp_valid && !osd_empty && !head;
    m1_resp_valid  = !rst && out_resp_valid && !osd_empty &&  head;
    out_resp_ready = 1'b0;
    if (!rst) begin
      out_resp_ready = osd_empty ? 1'b1 : (head ? m1_resp_ready : m0_resp_ready);
    end
  end

  assign push = out_req_valid && out_req_ready;
  assign pop  = out_resp_valid && out_resp_ready && !osd_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr             <= 1'b0;
      owner_q        <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      osd_cnt        <= '0;
      err_unexp_resp <= 1'b0;
    end else begin
      if (push) begin
        owner_q[wr_ptr] <= grant;
        wr_ptr          <= wr_ptr + 1'b1;
        rr              <= ~grant;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   osd_cnt <= osd_cnt + 1'b1;
        2'b01:   osd_cnt <= osd_cnt - 1'b1;
        default: osd_cnt <= osd_cnt;
      endcase
      if (out_resp_valid && osd_empty) begin
        err_unexp_resp <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_noc_arb.sv
// Directed bench for mem_noc_arb: expected requests/responses are queued as
// stimulus is issued and a monitor pops them on every DUT handshake.
module tb_mem_noc_arb;
  import mem_noc_pkg::*;

  localparam int OSD    = 4;
  localparam int REQ_W  = $bits(mem_req_t);
  localparam int RESP_W = $bits(mem_resp_t);

  logic        clk;
  logic        rst;
  logic        m0_req_valid, m0_req_ready, m0_resp_valid, m0_resp_ready;
  logic        m1_req_valid, m1_req_ready, m1_resp_valid, m1_resp_ready;
  mem_req_t    m0_req, m1_req, out_req;
  mem_resp_t   m0_resp, m1_resp, out_resp;
  logic        out_req_valid, out_req_ready, out_resp_valid, out_resp_ready;
  logic [$clog2(OSD):0] osd_cnt;
  logic        err_unexp_resp;
  logic [1:0]  arb_state;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          ds_auto;
  logic        man_valid, ds_valid;
  mem_resp_t   man_data, ds_data;

  logic [REQ_W-1:0]  exp_req_q[$];
  logic [RESP_W-1:0] exp_r0_q[$];
  logic [RESP_W-1:0] exp_r1_q[$];
  logic [RESP_W-1:0] pend_q[$];
  int                pend_due_q[$];

  assign out_resp_valid = ds_auto ? ds_valid : man_valid;
  assign out_resp       = ds_auto ? ds_data  : man_data;

  mem_noc_arb #(.OSD(OSD)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req(m0_req),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready), .m0_resp(m0_resp),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req(m1_req),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready), .m1_resp(m1_resp),
    .out_req_valid(out_req_valid), .out_req_ready(out_req_ready), .out_req(out_req),
    .out_resp_valid(out_resp_valid), .out_resp_ready(out_resp_ready), .out_resp(out_resp),
    .osd_cnt(osd_cnt), .err_unexp_resp(err_unexp_resp), .arb_state(arb_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic mem_req_t mk_req(input bit port, input int k);
    mem_req_t r;
    r.we    = k[0];
    r.addr  = {port, 7'd0, k[7:0]};
    r.wdata = 32'hA000_0000 | (32'(port) << 12) | 32'(k);
    return r;
  endfunction

  function automatic mem_resp_t resp_of(input mem_req_t r);
    mem_resp_t s;
    s.rdata = r.wdata ^ 32'h5A5A_0000;
    s.err   = r.addr[0];
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic exp_req(input bit port, input int k, input bit want_resp);
    exp_req_q.push_back(mk_req(port, k));
    if (want_resp) begin
      if (port) exp_r1_q.push_back(resp_of(mk_req(port, k)));
      else      exp_r0_q.push_back(resp_of(mk_req(port, k)));
    end
  endtask

  task automatic idle_inputs();
    m0_req_valid  = 1'b0;
    m1_req_valid  = 1'b0;
    m0_req        = '0;
    m1_req        = '0;
    m0_resp_ready = 1'b1;
    m1_resp_ready = 1'b1;
    out_req_ready = 1'b1;
    man_valid     = 1'b0;
    man_data      = '0;
    ds_auto       = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send_resp(input mem_resp_t d);
    int n;
    man_valid = 1'b1;
    man_data  = d;
    neg();
    n = 0;
    while (!out_resp_ready && n < 20) begin
      tick();
      neg();
      n++;
    end
    check("resp_accept", out_resp_ready, 1);
    tick();
    man_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60 && (exp_req_q.size() + exp_r0_q.size() + exp_r1_q.size()) != 0; i++) tick();
    check("drain", exp_req_q.size() + exp_r0_q.size() + exp_r1_q.size(), 0);
  endtask

  // Scoreboard monitor: every DUT-side handshake pops its expected queue
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_req_valid && out_req_ready) begin
          if (exp_req_q.size() == 0) check("out_req_extra", 1, 0);
          else check("out_req", out_req, exp_req_q.pop_front());
        end
        if (m0_resp_valid && m0_resp_ready) begin
          if (exp_r0_q.size() == 0) check("m0_resp_extra", 1, 0);
          else check("m0_resp", m0_resp, exp_r0_q.pop_front());
        end
        if (m1_resp_valid && m1_resp_ready) begin
          if (exp_r1_q.size() == 0) check("m1_resp_extra", 1, 0);
          else check("m1_resp", m1_resp, exp_r1_q.pop_front());
        end
      end
    end
  endtask

  // Downstream memory model: answers each accepted request two cycles later
  task automatic downstream();
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_q.delete();
        pend_due_q.delete();
      end else if (ds_auto) begin
        if (out_resp_valid && out_resp_ready && pend_q.size() != 0) begin
          void'(pend_q.pop_front());
          void'(pend_due_q.pop_front());
        end
        if (out_req_valid && out_req_ready) begin
          pend_q.push_back(resp_of(out_req));
          pend_due_q.push_back(cyc + 2);
        end
      end
      @(posedge clk);
      #1;
      ds_valid = 1'b0;
      ds_data  = '0;
      if (ds_auto && pend_q.size() != 0 && pend_due_q[0] <= cyc) begin
        ds_valid = 1'b1;
        ds_data  = pend_q[0];
      end
    end
  endtask

  initial begin
    int  i0, i1;
    bit  a0, a1;
    rst = 1'b1;
    ds_valid = 1'b0;
    ds_data  = '0;
    idle_inputs();
    fork
      monitor();
      downstream();
    join_none

    // Reset: outputs quiet even with every input asserted
    m0_req_valid = 1'b1;
    m1_req_valid = 1'b1;
    man_valid    = 1'b1;
    neg();
    check("rst_m0_req_ready", m0_req_ready, 0);
    check("rst_m1_req_ready", m1_req_ready, 0);
    check("rst_out_req_valid", out_req_valid, 0);
    check("rst_m0_resp_valid", m0_resp_valid, 0);
    check("rst_m1_resp_valid", m1_resp_valid, 0);
    check("rst_out_resp_ready", out_resp_ready, 0);
    tick();
    idle_inputs();
    rst = 1'b0;
    neg();
    check("rst_osd_cnt", osd_cnt, 0);
    check("rst_err", err_unexp_resp, 0);
    check("rst_arb_state", arb_state, 0);
    tick();

    // Both ports always valid: grants alternate 0,1,0,1 and responses return in order
    ds_auto = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_req(0, k, 1);
      exp_req(1, k, 1);
    end
    i0 = 0;
    i1 = 0;
    for (int c = 0; c < 40 && (i0 < 4 || i1 < 4); c++) begin
      m0_req_valid = (i0 < 4);
      m0_req       = mk_req(0, i0);
      m1_req_valid = (i1 < 4);
      m1_req       = mk_req(1, i1);
      neg();
      a0 = m0_req_valid && m0_req_ready;
      a1 = m1_req_valid && m1_req_ready;
      tick();
      i0 += int'(a0);
      i1 += int'(a1);
    end
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b0;
    check("rr_issued", i0 + i1, 8);
    wait_drain();
    neg();
    check("rr_osd_cnt", osd_cnt, 0);
    tick();

    // Locked grant: stalled m0 offer is held even though rr now prefers m1
    do_reset();
    ds_auto = 1'b1;
    m0_req_valid = 1'b1;
    m0_req       = mk_req(0, 8);
    exp_req(0, 8, 1);
    neg();
    check("lock_warm_ready", m0_req_ready, 1);
    tick();
    m0_req_valid = 1'b0;
    repeat (4) tick();
    for (int c = 0; c < 4; c++) begin
      m0_req_valid  = 1'b1;
      m0_req        = mk_req(0, 9);
      m1_req_valid  = (c >= 1);
      m1_req        = mk_req(1, 9);
      out_req_ready = (c == 3);
      if (c == 3) exp_req(0, 9, 1);
      neg();
      check("lock_out_valid", out_req_valid, 1);
      check("lock_out_payload", out_req, mk_req(0, 9));
      check("lock_m1_ready", m1_req_ready, 0);
      check("lock_m0_ready", m0_req_ready, (c == 3));
      if (c == 1) check("lock_state", arb_state, 2'b10);
      tick();
    end
    m0_req_valid = 1'b0;
    exp_req(1, 9, 1);
    neg();
    check("lock_m1_after", m1_req_ready, 1);
    tick();
    m1_req_valid = 1'b0;
    wait_drain();

    // Full: four outstanding block both ports, even when a response pops
    do_reset();
    for (int k = 0; k < 4; k++) begin
      m0_req_valid = 1'b1;
      m0_req       = mk_req(0, k);
      exp_req(0, k, 1);
      neg();
      check("full_fill_ready", m0_req_ready, 1);
      tick();
    end
    m0_req       = mk_req(0, 4);
    m1_req_valid = 1'b1;
    m1_req       = mk_req(1, 4);
    neg();
    check("full_osd_cnt", osd_cnt, 4);
    check("full_out_valid", out_req_valid, 0);
    check("full_m0_ready", m0_req_ready, 0);
    check("full_m1_ready", m1_req_ready, 0);
    tick();
    m1_req_valid = 1'b0;
    man_valid    = 1'b1;
    man_data     = resp_of(mk_req(0, 0));
    neg();
    check("full_pop_ready", out_resp_ready, 1);
    check("full_pop_m0_resp_valid", m0_resp_valid, 1);
    check("full_pop_no_accept", m0_req_ready, 0);
    tick();
    man_valid = 1'b0;
    exp_req(0, 4, 1);
    neg();
    check("full_after_pop_cnt", osd_cnt, 3);
    check("full_after_pop_ready", m0_req_ready, 1);
    tick();
    m0_req_valid = 1'b0;
    for (int k = 1; k < 5; k++) send_resp(resp_of(mk_req(0, k)));
    neg();
    check("full_drained_cnt", osd_cnt, 0);
    tick();

    // Simultaneous push and pop keeps the count and the routing order
    do_reset();
    m0_req_valid = 1'b1;
    m0_req       = mk_req(0, 10);
    exp_req(0, 10, 1);
    tick();
    m0_req_valid = 1'b0;
    m1_req_valid = 1'b1;
    m1_req       = mk_req(1, 10);
    exp_req(1, 10, 1);
    tick();
    m1_req_valid = 1'b0;
    m0_req_valid = 1'b1;
    m0_req       = mk_req(0, 11);
    exp_req(0, 11, 1);
    man_valid    = 1'b1;
    man_data     = resp_of(mk_req(0, 10));
    neg();
    check("pp_osd_before", osd_cnt, 2);
    check("pp_req_ready", m0_req_ready, 1);
    check("pp_resp_ready", out_resp_ready, 1);
    tick();
    m0_req_valid = 1'b0;
    man_valid    = 1'b0;
    neg();
    check("pp_osd_after", osd_cnt, 2);
    tick();
    send_resp(resp_of(mk_req(1, 10)));
    send_resp(resp_of(mk_req(0, 11)));
    neg();
    check("pp_drained_cnt", osd_cnt, 0);
    tick();

    // Head owner m1 stalls: downstream sees backpressure, nothing leaks to m0
    m1_req_valid = 1'b1;
    m1_req       = mk_req(1, 12);
    exp_req(1, 12, 1);
    tick();
    m1_req_valid  = 1'b0;
    m1_resp_ready = 1'b0;
    man_valid     = 1'b1;
    man_data      = resp_of(mk_req(1, 12));
    for (int c = 0; c < 2; c++) begin
      neg();
      check("bp_out_resp_ready", out_resp_ready, 0);
      check("bp_m0_resp_valid", m0_resp_valid, 0);
      check("bp_m1_resp_valid", m1_resp_valid, 1);
      check("bp_osd_cnt", osd_cnt, 1);
      tick();
    end
    m1_resp_ready = 1'b1;
    neg();
    check("bp_release_ready", out_resp_ready, 1);
    tick();
    man_valid = 1'b0;
    neg();
    check("bp_osd_done", osd_cnt, 0);
    tick();

    // Reset mid-transaction drops ownership; the late response is unexpected
    m0_req_valid = 1'b1;
    m0_req       = mk_req(0, 13);
    exp_req(0, 13, 0);
    neg();
    check("mid_accept", m0_req_ready, 1);
    tick();
    m0_req_valid = 1'b0;
    rst          = 1'b1;
    neg();
    check("mid_rst_osd", osd_cnt, 0);
    check("mid_rst_out_resp_ready", out_resp_ready, 0);
    tick();
    rst = 1'b0;
    neg();
    check("mid_post_osd", osd_cnt, 0);
    check("mid_post_err", err_unexp_resp, 0);
    tick();
    man_valid = 1'b1;
    man_data  = resp_of(mk_req(0, 13));
    neg();
    check("unexp_ready", out_resp_ready, 1);
    check("unexp_m0_valid", m0_resp_valid, 0);
    check("unexp_m1_valid", m1_resp_valid, 0);
    tick();
    man_valid = 1'b0;
    neg();
    check("unexp_err_set", err_unexp_resp, 1);
    tick();
    repeat (3) tick();
    neg();
    check("unexp_err_sticky", err_unexp_resp, 1);
    check("unexp_osd_cnt", osd_cnt, 0);
    tick();
    do_reset();
    neg();
    check("unexp_err_cleared", err_unexp_resp, 0);
    check("final_queues", exp_req_q.size() + exp_r0_q.size() + exp_r1_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
